bus_arbiter: RTL and testbench

- Shares the single bus-controller master port (bm_*) between NUM_MASTERS requesters, e.g. CPU instruction fetch, CPU data and DMA.
- Round-robin arbitration. The winner owns the bus until it drops read/write.
- Inserts one idle cycle between owners, so the bus controller returns to its idle state and re-decodes chip select for the new address.
- Sits between the masters and the bus controller; slaves and chip selects are unaffected.

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter that shares one bus-controller master port (bm_*) between
// NUM_MASTERS requesters. The winner keeps the bus until it drops read/write.
// One idle cycle is inserted between owners so the bus controller goes back to
// idle and re-decodes chip select for the new address.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   m_address         packed per-master addresses, master i at [AW*i +: AW]
//   m_writedata       packed per-master write data, master i at [DW*i +: DW]
//   m_read, m_write   per-master read / write requests
//   m_wait            per-master stall
//   m_readdata        bm_readdata broadcast to every master
//   bm_address, bm_writedata, bm_read, bm_write   to the bus controller
//   bm_readdata, bm_wait                          from the bus controller
//   grant             one-hot current owner, 0 when nobody owns the bus
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [AW*NUM_MASTERS-1:0] m_address,
    input  logic [DW*NUM_MASTERS-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]    m_read,
    input  logic [NUM_MASTERS-1:0]    m_write,
    output logic [NUM_MASTERS-1:0]    m_wait,
    output logic [DW-1:0]             m_readdata,
    output logic [AW-1:0]             bm_address,
    output logic [DW-1:0]             bm_writedata,
    output logic                      bm_read,
    output logic                      bm_write,
    input  logic [DW-1:0]             bm_readdata,
    input  logic                      bm_wait,
    output logic [NUM_MASTERS-1:0]    grant
);

    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]             r_state;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_last;

    logic [1:0]             w_state_nxt;
    logic [IW-1:0]          w_owner_nxt;
    logic [IW-1:0]          w_last_nxt;
    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_any_req;
    logic                   w_owner_req;
    logic [IW-1:0]          w_sel;

    assign w_req      = m_read | m_write;
    assign w_any_req  = |w_req;
    assign m_readdata = bm_readdata;

    // Round-robin pick: first requester scanning from last+1 with wrap.
    // Scanning distances high-to-low lets the nearest requester overwrite.
    always_comb begin
        w_sel = r_last;
        for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if ((i == ((int'(r_last) + k) % int'(NUM_MASTERS))) && w_req[i]) begin
                    w_sel = IW'(i);
                end
            end
        end
    end

    // Request line of the current owner.
    always_comb begin
        w_owner_req = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (r_owner == IW'(i)) begin
                w_owner_req = w_req[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic; GAP arbitrates exactly like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_any_req) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_sel;
                    w_last_nxt  = w_sel;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus mux from the registered owner; non-owners stall on their own request.
    // bm_wait reaches only m_wait, never the state logic.
    always_comb begin
        bm_address   = '0;
        bm_writedata = '0;
        bm_read      = 1'b0;
        bm_write     = 1'b0;
        grant        = '0;
        m_wait       = w_req;
        if (r_state == ST_OWN) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (r_owner == IW'(i)) begin
                    bm_address   = m_address[AW*i +: AW];
                    bm_writedata = m_writedata[DW*i +: DW];
                    bm_read      = m_read[i];
                    bm_write     = m_write[i];
                    grant[i]     = 1'b1;
                    m_wait[i]    = bm_wait;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter with 3 masters, 32-bit address and data.
// Inputs change and outputs are checked just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [AW*N-1:0]   m_address;
    logic [DW*N-1:0]   m_writedata;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N-1:0]      m_wait;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     bm_address;
    logic [DW-1:0]     bm_writedata;
    logic              bm_read;
    logic              bm_write;
    logic [DW-1:0]     bm_readdata;
    logic              bm_wait;
    logic [N-1:0]      grant;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_wait       (m_wait),
        .m_readdata   (m_readdata),
        .bm_address   (bm_address),
        .bm_writedata (bm_writedata),
        .bm_read      (bm_read),
        .bm_write     (bm_write),
        .bm_readdata  (bm_readdata),
        .bm_wait      (bm_wait),
        .grant        (grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic set_m(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_read[i]                 = rd;
        m_write[i]                = wr;
        m_address[AW*i +: AW]     = a;
        m_writedata[DW*i +: DW]   = d;
    endtask

    task automatic clear_all;
        for (int i = 0; i < int'(N); i++) set_m(i, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        m_address   = '0;
        m_writedata = '0;
        m_read      = '0;
        m_write     = '0;
        bm_readdata = '0;
        bm_wait     = 1'b0;
        reset       = 1'b1;
        tick;
        tick;
        chk("rst_grant",   64'(grant),      64'h0);
        chk("rst_bm_read", 64'(bm_read),    64'h0);
        chk("rst_bm_addr", 64'(bm_address), 64'h0);
        chk("rst_m_wait",  64'(m_wait),     64'h0);
        reset = 1'b0;

        // Single read from master 0
        set_m(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        #1;
        chk("t1_idle_wait",  64'(m_wait), 64'b001);
        chk("t1_idle_grant", 64'(grant),  64'h0);
        tick;
        chk("t1_grant",   64'(grant),      64'b001);
        chk("t1_bm_read", 64'(bm_read),    64'h1);
        chk("t1_bm_addr", 64'(bm_address), 64'h100);
        chk("t1_wait_lo", 64'(m_wait),     64'b000);
        bm_wait = 1'b1;
        #1;
        chk("t1_wait_hi", 64'(m_wait), 64'b001);
        bm_wait = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0000_0100, '0);
        #1;
        chk("t1_drop_read",  64'(bm_read), 64'h0);
        chk("t1_drop_grant", 64'(grant),   64'b001);
        tick;
        chk("t1_gap_grant", 64'(grant),   64'h0);
        chk("t1_gap_read",  64'(bm_read), 64'h0);
        tick;
        chk("t1_idle2_grant", 64'(grant), 64'h0);

        // Simultaneous read (m0) and write (m2) after reset
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h0000_0000, '0);
        set_m(2, 1'b0, 1'b1, 32'hffff_c010, 32'hdead_beef);
        #1;
        chk("t2_idle_wait", 64'(m_wait), 64'b101);
        tick;
        chk("t2_grant0",   64'(grant),    64'b001);
        chk("t2_wait0",    64'(m_wait),   64'b100);
        chk("t2_bm_write", 64'(bm_write), 64'h0);
        tick;
        chk("t2_wait1", 64'(m_wait), 64'b100);
        set_m(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t2_drop_write", 64'(bm_write), 64'h0);
        tick;
        chk("t2_gap_write", 64'(bm_write), 64'h0);
        chk("t2_gap_grant", 64'(grant),    64'h0);
        chk("t2_gap_wait",  64'(m_wait),   64'b100);
        tick;
        chk("t2_grant2", 64'(grant),        64'b100);
        chk("t2_write",  64'(bm_write),     64'h1);
        chk("t2_read",   64'(bm_read),      64'h0);
        chk("t2_addr",   64'(bm_address),   64'hffff_c010);
        chk("t2_data",   64'(bm_writedata), 64'hdead_beef);
        chk("t2_wait2",  64'(m_wait),       64'b000);
        clear_all;
        tick;
        tick;

        // All three re-request after every completion: strict rotation
        for (int i = 0; i < int'(N); i++) set_m(i, 1'b1, 1'b0, 32'h1000 + 32'(i), '0);
        tick;
        for (int t = 0; t < 9; t++) begin
            int o;
            o = t % 3;
            chk("t3_grant", 64'(grant),      64'(1 << o));
            chk("t3_addr",  64'(bm_address), 64'(32'h1000 + 32'(o)));
            set_m(o, 1'b0, 1'b0, 32'h1000 + 32'(o), '0);
            tick;
            chk("t3_gap", 64'(grant), 64'h0);
            set_m(o, 1'b1, 1'b0, 32'h1000 + 32'(o), '0);
            tick;
        end
        chk("t3_wrap", 64'(grant), 64'b001);
        clear_all;
        tick;
        tick;

        // Master 1 holds the bus for 20 cycles with master 0 waiting
        set_m(0, 1'b1, 1'b0, 32'h0000_0040, '0);
        set_m(1, 1'b1, 1'b0, 32'h0000_2000, '0);
        tick;
        for (int c = 0; c < 20; c++) begin
            chk("t4_hold_grant", 64'(grant),  64'b010);
            chk("t4_hold_wait",  64'(m_wait), 64'b001);
            tick;
        end
        set_m(1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t4_drop_grant", 64'(grant), 64'b010);
        tick;
        chk("t4_gap_grant", 64'(grant), 64'h0);
        tick;
        chk("t4_m0_grant", 64'(grant),      64'b001);
        chk("t4_m0_addr",  64'(bm_address), 64'h40);
        clear_all;
        tick;
        tick;

        // Reset while a read is on the bus
        set_m(1, 1'b1, 1'b0, 32'h0000_3000, '0);
        tick;
        chk("t5_own_read",  64'(bm_read), 64'h1);
        chk("t5_own_grant", 64'(grant),   64'b010);
        reset = 1'b1;
        tick;
        chk("t5_rst_read",  64'(bm_read), 64'h0);
        chk("t5_rst_grant", 64'(grant),   64'h0);
        reset = 1'b0;
        set_m(1, 1'b0, 1'b0, '0, '0);
        set_m(0, 1'b1, 1'b0, 32'h0000_0010, '0);
        set_m(2, 1'b1, 1'b0, 32'h0000_0020, '0);
        tick;
        chk("t5_first_grant", 64'(grant), 64'b001);
        clear_all;
        tick;
        tick;

        // Read-data broadcast while master 1 is not requesting
        bm_readdata = 32'h1234_5678;
        set_m(0, 1'b1, 1'b0, 32'h0080_0004, '0);
        tick;
        chk("t6_grant",    64'(grant),      64'b001);
        chk("t6_addr",     64'(bm_address), 64'h0080_0004);
        chk("t6_wait",     64'(m_wait),     64'b000);
        chk("t6_readdata", 64'(m_readdata), 64'h1234_5678);
        bm_wait = 1'b1;
        #1;
        chk("t6_wait_stall", 64'(m_wait), 64'b001);
        bm_wait = 1'b0;
        clear_all;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
